if_id_skid: RTL and testbench

Parametrised IF/ID pipeline boundary with valid/ready handshake, a 2-entry skid buffer, and a flush path. It sits between fetch and decode. Fetch can keep issuing for one cycle after decode stalls without losing or duplicating an instruction. A branch or exception flush discards everything in flight and presents a NOP bubble to decode.

---
 rtl/if_id_skid_if.sv | 14 +
 rtl/if_id_skid.sv | 96 +++++++++
 tb/tb_if_id_skid.sv | 137 +++++++++++++
 3 files changed

// File: rtl/if_id_skid_if.sv
// Valid/ready beat bus carrying one fetched instruction and its pc.
// The producer uses the master modport and the consumer uses the slave modport.
interface if_id_skid_if #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);
endinterface

// File: rtl/if_id_skid.sv
// IF/ID pipeline boundary: a main register that drives decode, plus a single skid entry.
// The skid entry absorbs the one beat fetch can still issue after decode stalls.
module if_id_skid #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'hD503201F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    if_id_skid_if.slave  fe,
    if_id_skid_if.master de,
    output logic [1:0]  occupancy
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e            state_q, state_d;
    logic              id_valid_q, id_valid_d;
    logic              if_ready_q, if_ready_d;
    logic [ADDR_W-1:0] id_pc_q, id_pc_d;
    logic [INST_W-1:0] id_inst_q, id_inst_d;
    logic [ADDR_W-1:0] s_pc_q, s_pc_d;
    logic [INST_W-1:0] s_inst_q, s_inst_d;
    logic              accept, take;

    // The skid entry is valid exactly in FULL, so the state carries its valid bit.
    always_comb begin
        accept    = fe.valid & if_ready_q;
        take      = id_valid_q & de.ready;
        state_d   = state_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        s_pc_d    = s_pc_q;
        s_inst_d  = s_inst_q;
        if (flush) begin
            state_d   = EMPTY;
            id_pc_d   = '0;
            id_inst_d = NOP_INST;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    id_pc_d   = fe.pc;
                    id_inst_d = fe.inst;
                    state_d   = ONE;
                end
                ONE: begin
                    if (take && accept) begin
                        id_pc_d   = fe.pc;
                        id_inst_d = fe.inst;
                    end else if (take) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        s_pc_d   = fe.pc;
                        s_inst_d = fe.inst;
                        state_d  = FULL;
                    end
                end
                FULL: if (take) begin
                    id_pc_d   = s_pc_q;
                    id_inst_d = s_inst_q;
                    state_d   = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registering ready off the next state keeps id_ready out of the if_ready path.
        id_valid_d = (state_d != EMPTY);
        if_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            id_valid_q <= 1'b0;
            if_ready_q <= 1'b1;
            id_pc_q    <= '0;
            id_inst_q  <= '0;
            s_pc_q     <= '0;
            s_inst_q   <= '0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            if_ready_q <= if_ready_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            s_pc_q     <= s_pc_d;
            s_inst_q   <= s_inst_d;
        end
    end

    assign fe.ready  = if_ready_q;
    assign de.valid  = id_valid_q;
    assign de.pc     = id_pc_q;
    assign de.inst   = id_inst_q;
    assign occupancy = state_q;
endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table for the corner cases, then random
// traffic checked against a queue model of the held beats.
module tb_if_id_skid;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam logic [31:0] NOP = 32'hD503201F;

    logic       clk = 1'b0;
    logic       rst, flush;
    logic [1:0] occupancy;

    if_id_skid_if #(.ADDR_W(AW), .INST_W(IW)) fe_if ();
    if_id_skid_if #(.ADDR_W(AW), .INST_W(IW)) de_if ();

    if_id_skid #(.ADDR_W(AW), .INST_W(IW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fe(fe_if.slave), .de(de_if.master), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, flush, iv, idr;
        logic [31:0] pc;
        logic        ev;
        logic [31:0] epc, einst;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    typedef struct { logic [31:0] pc, inst; } beat_t;

    vec_t  vt[$];
    beat_t mq[$];
    int    total = 0;
    int    bad   = 0;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0000;
    endfunction

    function automatic void add(input logic r, f, iv, idr, input logic [31:0] pc,
                                input logic ev, input logic [31:0] epc, einst,
                                input logic [1:0] eocc, input logic erdy);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.idr = idr; v.pc = pc;
        v.ev = ev; v.epc = epc; v.einst = einst; v.eocc = eocc; v.erdy = erdy;
        vt.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        fe_if.valid = 1'b0; fe_if.pc = '0; fe_if.inst = '0; de_if.ready = 1'b0;

        //  rst f iv idr pc          ev epc          einst             occ rdy
        add(1, 0, 0, 0, 32'h0,      0, 32'h0,    32'h0,           0, 1); // reset
        add(1, 0, 1, 1, 32'h9,      0, 32'h0,    32'h0,           0, 1);
        add(0, 0, 1, 1, 32'h1000,   1, 32'h1000, ins(32'h1000),   1, 1); // stream
        add(0, 0, 1, 1, 32'h1004,   1, 32'h1004, ins(32'h1004),   1, 1);
        add(0, 0, 1, 1, 32'h1008,   1, 32'h1008, ins(32'h1008),   1, 1);
        add(0, 0, 0, 1, 32'h0,      0, 32'h1008, ins(32'h1008),   0, 1); // drain, pc holds
        add(0, 0, 1, 0, 32'h2000,   1, 32'h2000, ins(32'h2000),   1, 1); // stall/skid
        add(0, 0, 1, 0, 32'h2004,   1, 32'h2000, ins(32'h2000),   2, 0);
        add(0, 0, 1, 0, 32'h2008,   1, 32'h2000, ins(32'h2000),   2, 0);
        add(0, 0, 1, 1, 32'h2008,   1, 32'h2004, ins(32'h2004),   1, 1);
        add(0, 0, 1, 1, 32'h2008,   1, 32'h2008, ins(32'h2008),   1, 1);
        add(0, 0, 0, 1, 32'h0,      0, 32'h2008, ins(32'h2008),   0, 1);
        add(0, 0, 1, 0, 32'h3000,   1, 32'h3000, ins(32'h3000),   1, 1); // flush in FULL
        add(0, 0, 1, 0, 32'h3004,   1, 32'h3000, ins(32'h3000),   2, 0);
        add(0, 1, 1, 0, 32'h3008,   0, 32'h0,    NOP,             0, 1);
        add(0, 1, 1, 1, 32'h300C,   0, 32'h0,    NOP,             0, 1); // back-to-back flush
        add(0, 0, 0, 1, 32'h0,      0, 32'h0,    NOP,             0, 1);
        add(0, 0, 1, 1, 32'h4000,   1, 32'h4000, ins(32'h4000),   1, 1); // single beat
        add(0, 0, 0, 1, 32'h0,      0, 32'h4000, ins(32'h4000),   0, 1);
        add(0, 0, 0, 1, 32'h0,      0, 32'h4000, ins(32'h4000),   0, 1);
        add(0, 0, 1, 0, 32'h5000,   1, 32'h5000, ins(32'h5000),   1, 1); // reset beats flush
        add(0, 0, 1, 0, 32'h5004,   1, 32'h5000, ins(32'h5000),   2, 0);
        add(1, 1, 1, 1, 32'h5008,   0, 32'h0,    32'h0,           0, 1);
        add(0, 0, 1, 1, 32'h6000,   1, 32'h6000, ins(32'h6000),   1, 1);
        add(0, 1, 1, 1, 32'h6004,   0, 32'h0,    NOP,             0, 1); // flush in ONE

        for (int i = 0; i < vt.size(); i++) begin
            rst = vt[i].rst; flush = vt[i].flush;
            fe_if.valid = vt[i].iv; fe_if.pc = vt[i].pc; fe_if.inst = ins(vt[i].pc);
            de_if.ready = vt[i].idr;
            @(posedge clk); #1;
            chk($sformatf("row%0d.id_valid", i), 32'(de_if.valid), 32'(vt[i].ev));
            chk($sformatf("row%0d.id_pc", i), de_if.pc, vt[i].epc);
            chk($sformatf("row%0d.id_inst", i), de_if.inst, vt[i].einst);
            chk($sformatf("row%0d.occupancy", i), 32'(occupancy), 32'(vt[i].eocc));
            chk($sformatf("row%0d.if_ready", i), 32'(fe_if.ready), 32'(vt[i].erdy));
        end

        // Random traffic: the model is simply the ordered list of beats being held.
        rst = 1'b1; flush = 1'b0; fe_if.valid = 1'b0; de_if.ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            beat_t b;
            logic  iv, idr, fl, tk, ac;
            iv  = ($urandom_range(0, 3) != 0);
            idr = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 49) == 0);
            b.pc = $urandom; b.inst = $urandom;
            flush = fl; fe_if.valid = iv; fe_if.pc = b.pc; fe_if.inst = b.inst;
            de_if.ready = idr;

            chk("rnd.occupancy", 32'(occupancy), mq.size());
            chk("rnd.if_ready", 32'(fe_if.ready), 32'(mq.size() < 2));
            chk("rnd.id_valid", 32'(de_if.valid), 32'(mq.size() > 0));
            chk("rnd.no_ready_when_full", 32'(fe_if.ready && occupancy == 2'd2), 32'd0);
            if (mq.size() > 0) begin
                chk("rnd.id_pc", de_if.pc, mq[0].pc);
                chk("rnd.id_inst", de_if.inst, mq[0].inst);
            end

            tk = (mq.size() > 0) && idr;
            ac = iv && (mq.size() < 2);
            @(posedge clk); #1;
            if (tk) void'(mq.pop_front());
            if (ac) mq.push_back(b);
            if (fl) mq.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
